// File: rtl/b2a_pkg.sv
// Shared definitions for the masked A2B/B2A conversion cores: default sizes,
// controller state encoding and ISW randomness bookkeeping.
package b2a_pkg;

    localparam int B2A_K_WIDTH  = 32;
    localparam int B2A_N_SHARES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int isw_rnd_bits(input int n);
        return n * (n - 1) / 2;
    endfunction

    // Position of the fresh bit r_ij (i < j) inside the packed ISW random vector.
    function automatic int isw_pair_idx(input int n, input int i, input int j);
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/sec_and_isw.sv
// Single-bit ISW masked AND over N_SHARES shares, purely combinational.
// Each output share is the XOR of one row of the ISW cross-product matrix.
module sec_and_isw
    import b2a_pkg::*;
#(
    parameter  int N_SHARES = B2A_N_SHARES,
    localparam int R_W      = isw_rnd_bits(N_SHARES)
) (
    input  logic [N_SHARES-1:0] x,
    input  logic [N_SHARES-1:0] y,
    input  logic [R_W-1:0]      r,
    output logic [N_SHARES-1:0] z
);

    logic [N_SHARES-1:0][N_SHARES-1:0] m;

    for (genvar i = 0; i < N_SHARES; i++) begin : g_row
        for (genvar j = 0; j < N_SHARES; j++) begin : g_col
            if (i == j) begin : g_diag
                assign m[i][j] = x[i] & y[i];
            end else if (i < j) begin : g_upper
                localparam int IDX = isw_pair_idx(N_SHARES, i, j);
                assign m[i][j] = r[IDX];
            end else begin : g_lower
                // Bracketing keeps the random bit folded in before the second product.
                localparam int IDX = isw_pair_idx(N_SHARES, j, i);
                assign m[i][j] = (r[IDX] ^ (x[j] & y[i])) ^ (x[i] & y[j]);
            end
        end
        assign z[i] = ^m[i];
    end

endmodule

// File: rtl/a2b_serial.sv
// Masked arithmetic-to-Boolean converter: adds the arithmetic shares one at a
// time into a Boolean-shared accumulator with a bit-serial masked ripple-carry.
module a2b_serial
    import b2a_pkg::*;
#(
    parameter  int K_WIDTH  = B2A_K_WIDTH,
    parameter  int N_SHARES = B2A_N_SHARES,
    localparam int RND_W    = N_SHARES * (N_SHARES - 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          dvld,
    input  logic [K_WIDTH*N_SHARES-1:0]   a,
    input  logic [RND_W-1:0]              rnd,
    output logic                          rdy,
    output logic [K_WIDTH*N_SHARES-1:0]   b,
    output logic                          ovld,
    output state_e                        dbg_state
);

    // Handshake: a job is taken on a clock edge where dvld & rdy & ena are all
    // high; dvld at any other time is dropped. ovld is a one-cycle pulse with b.
    localparam int W    = K_WIDTH * N_SHARES;
    localparam int JW   = (K_WIDTH > 1) ? $clog2(K_WIDTH) : 1;
    localparam int IW   = $clog2(N_SHARES);
    localparam int HALF = RND_W / 2;

    state_e              state_q, state_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        acc_q, acc_d;
    logic [W-1:0]        b_q, b_d;
    logic [K_WIDTH-1:0]  c_q, c_d;
    logic [N_SHARES-1:0] carry_q, carry_d;
    logic [IW-1:0]       i_q, i_d, i_nxt;
    logic [JW-1:0]       j_q, j_d;
    logic                ovld_q, ovld_d;

    logic [N_SHARES-1:0] x_v, y_v, xy_v, sum_v, z0, z1;
    logic [W-1:0]        acc_run;
    logic                last_bit, last_share;

    assign last_bit   = (j_q == JW'(K_WIDTH - 1));
    assign last_share = (i_q == IW'(N_SHARES - 1));
    assign i_nxt      = i_q + IW'(1);

    // Operand C is non-zero only in share 0, so the other lanes see y = 0.
    assign y_v  = {{(N_SHARES-1){1'b0}}, c_q[j_q]};
    assign xy_v = x_v ^ y_v;

    for (genvar n = 0; n < N_SHARES; n++) begin : g_lane
        logic [K_WIDTH-1:0] lane;
        assign lane     = acc_q[n*K_WIDTH +: K_WIDTH];
        assign x_v[n]   = lane[j_q];
        assign sum_v[n] = x_v[n] ^ y_v[n] ^ carry_q[n];
        assign acc_run[n*K_WIDTH +: K_WIDTH] =
            (lane & ~(K_WIDTH'(1) << j_q)) | (K_WIDTH'(sum_v[n]) << j_q);
    end

    sec_and_isw #(.N_SHARES(N_SHARES)) u_and_xy (
        .x (x_v),
        .y (y_v),
        .r (rnd[0 +: HALF]),
        .z (z0)
    );

    sec_and_isw #(.N_SHARES(N_SHARES)) u_and_cp (
        .x (carry_q),
        .y (xy_v),
        .r (rnd[HALF +: HALF]),
        .z (z1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            c_q     <= '0;
            carry_q <= '0;
            i_q     <= '0;
            j_q     <= '0;
            ovld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            i_q     <= i_d;
            j_q     <= j_d;
            ovld_q  <= ovld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ena) begin
            case (state_q)
                IDLE:    if (dvld) state_d = RUN;
                RUN:     if (last_bit && last_share) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        a_d     = a_q;
        acc_d   = acc_q;
        b_d     = b_q;
        c_d     = c_q;
        carry_d = carry_q;
        i_d     = i_q;
        j_d     = j_q;
        ovld_d  = ena && (state_q == DONE);
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (dvld) begin
                        a_d     = a;
                        acc_d   = W'(a[K_WIDTH-1:0]);
                        c_d     = a[2*K_WIDTH-1 -: K_WIDTH];
                        carry_d = '0;
                        i_d     = IW'(1);
                        j_d     = '0;
                    end
                end
                RUN: begin
                    acc_d = acc_run;
                    if (last_bit) begin
                        // Carry out of the top bit is the mod 2^K wrap: dropped.
                        carry_d = '0;
                        j_d     = '0;
                        i_d     = i_nxt;
                        if (!last_share) c_d = K_WIDTH'(a_q >> (K_WIDTH * int'(i_nxt)));
                    end else begin
                        carry_d = z0 ^ z1;
                        j_d     = j_q + JW'(1);
                    end
                end
                DONE:    b_d = acc_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        rdy       = (state_q == IDLE);
        ovld      = ovld_q;
        b         = b_q;
        dbg_state = state_q;
    end

endmodule
